xif_coproc_model: RTL and testbench
===================================

Name: xif_coproc_model

Overview:
- Parametrised CORE-V-XIF coprocessor reference model, the next step beyond bare interface instantiation in the test bench.
- Accepts custom-0 instructions over the issue handshake and buffers up to DEPTH in-flight entries.
- Applies commit/kill per id and returns in-order results over the result handshake after a programmable latency.
- Instantiated in the test top against core_v_xif signals. Serves as the functional stand-in for a real accelerator.

Parameters:
- X_ID_WIDTH, 4, width of instruction id.
- X_RFR_WIDTH, 32, register read/write data width (32 or 64).
- DEPTH, 4, max outstanding instructions (power of two, 2..16).
- LATENCY, 2, cycles from head-committed to result_valid_o (0..15).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  model can take an issue
- issue_instr_i  in  32  instruction word
- issue_id_i  in  X_ID_WIDTH  instruction id
- issue_rs1_i  in  X_RFR_WIDTH  source operand 1
- issue_rs2_i  in  X_RFR_WIDTH  source operand 2
- issue_accept_o  out  1  instruction is offloaded (valid with handshake)
- issue_writeback_o  out  1  instruction writes rd
- commit_valid_i  in  1  commit transaction
- commit_id_i  in  X_ID_WIDTH  committed id
- commit_kill_i  in  1  1 = discard, 0 = execute
- result_valid_o  out  1  result available
- result_ready_i  in  1  core accepts result
- result_id_o  out  X_ID_WIDTH  result id
- result_data_o  out  X_RFR_WIDTH  result value
- result_rd_o  out  5  destination register
- result_we_o  out  1  register write enable
- busy_o  out  1  any entry occupied

Behaviour:
- Reset: issue_ready_o=1 (when no other reason to stall), result_valid_o=0, busy_o=0, all other outputs 0. All entries invalid; pointers and latency counter cleared.
- Decode (combinational):
  - Accepted iff opcode[6:0]=7'b0001011 and funct3 ∈ {000 ADD, 001 XOR, 010 SLL by rs2[4:0]}.
  - issue_accept_o/issue_writeback_o=1 for accepted instructions, else 0.
  - issue_ready_o=!full.
- Issue handshake (valid&ready): an accepted instruction allocates the tail entry {id, rd=instr[11:7], data computed at issue, committed=0}. A non-accepted instruction allocates nothing.
- Full (DEPTH entries): issue_ready_o=0. The core must hold its request.
- Commit:
  - Matches the valid, uncommitted entry with id==commit_id_i.
  - kill=0 sets committed. kill=1 marks the entry killed.
  - No match: ignored.
  - Commit in the same cycle as the issue of the same id: applies to the newly allocated entry.
- Head processing, in order:
  - Killed head is freed in 1 cycle, no result.
  - Committed head starts the latency counter. result_valid_o rises LATENCY cycles after the head's committed flag is visible (LATENCY=0: same cycle the flag is registered).
  - result_valid_o holds with stable data until result_ready_i. On handshake, the head frees and the counter reloads.
  - result_we_o=1 always. Arithmetic wraps modulo 2^X_RFR_WIDTH.
- Simultaneous issue and result handshake when full: the freed slot is not usable for issue in the same cycle (ready derived from registered count).
- Uncommitted head blocks all later results (in-order return).
- busy_o = count!=0.
- Reset mid-operation: all entries are discarded immediately. No result is emitted after reset release until a new issue+commit.

Decomposition:
- xif_coproc_pkg:
  - opcode/funct3 constants.
  - entry_t struct {valid, committed, killed, id, rd, data}.
  - decode function returning {accept, op}.
- Sub-module xif_coproc_fifo: DEPTH-entry circular buffer with head/tail pointers, count, and id-match commit update port. The top holds decode, ALU, latency counter, and result handshake.

Test Plan:
- ADD id=3, rs1=5, rs2=7, commit kill=0 next cycle, LATENCY=2, ready=1 → result_valid_o 2 cycles after commit registers, data=12, id=3, rd=instr[11:7].
- Illegal opcode 7'b0110011 → issue_accept_o=0, busy_o stays 0, no result ever.
- Issue ids 0,1,2,3 (DEPTH=4) without commit → issue_ready_o=0 after the 4th handshake. Commit all (kill=0); results returned in order 0,1,2,3; issue_ready_o=1 after the first result handshake.
- Issue ids 5,6; kill id 5, commit id 6 → only id 6 returned; id 5 produces no result.
- Commit arriving the same cycle as the issue (XOR 0xFFFF_0000^0x0F0F_0F0F) → result 0xF0F0_0F0F.
- Hold result_ready_i=0 for 5 cycles with valid result → data/id stable. Assert rst_ni=0 mid-stall → result_valid_o=0 asynchronously, busy_o=0.

Source files
------------

// File: rtl/xif_coproc_pkg.sv
`default_nettype none
// ====================================================================
// xif_coproc_pkg : shared types, opcode constants and decode helper
// Rev 1.0
// ====================================================================
package xif_coproc_pkg;

   // Entry fields are sized for the widest supported configuration;
   // modules use the low X_ID_WIDTH / X_RFR_WIDTH bits.
   localparam int unsigned XIF_ID_MAX   = 16;
   localparam int unsigned XIF_DATA_MAX = 64;

   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
   localparam logic [2:0] F3_ADD      = 3'b000;
   localparam logic [2:0] F3_XOR      = 3'b001;
   localparam logic [2:0] F3_SLL      = 3'b010;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_XOR = 2'd1,
      OP_SLL = 2'd2
   } op_e;

   typedef struct packed {
      logic                    valid;
      logic                    committed;
      logic                    killed;
      logic [XIF_ID_MAX-1:0]   id;
      logic [4:0]              rd;
      logic [XIF_DATA_MAX-1:0] data;
   } entry_t;

   typedef struct packed {
      logic accept;
      op_e  op;
   } dec_t;

   function automatic dec_t decode(input logic [6:0] opcode, input logic [2:0] funct3);
      dec_t d;
      d.accept = 1'b0;
      d.op     = OP_ADD;
      if (opcode == OPC_CUSTOM0) begin
         case (funct3)
            F3_ADD:  begin d.accept = 1'b1; d.op = OP_ADD; end
            F3_XOR:  begin d.accept = 1'b1; d.op = OP_XOR; end
            F3_SLL:  begin d.accept = 1'b1; d.op = OP_SLL; end
            default: d.accept = 1'b0;
         endcase
      end
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/xif_coproc_if.sv
`default_nettype none
// ====================================================================
// xif_coproc_if : issue / commit / result handshake bundle
// Rev 1.0
// ====================================================================
interface xif_coproc_if #(
   parameter int unsigned X_ID_WIDTH  = 4,
   parameter int unsigned X_RFR_WIDTH = 32
);
   logic                   issue_valid_i;
   logic                   issue_ready_o;
   logic [31:0]            issue_instr_i;
   logic [X_ID_WIDTH-1:0]  issue_id_i;
   logic [X_RFR_WIDTH-1:0] issue_rs1_i;
   logic [X_RFR_WIDTH-1:0] issue_rs2_i;
   logic                   issue_accept_o;
   logic                   issue_writeback_o;
   logic                   commit_valid_i;
   logic [X_ID_WIDTH-1:0]  commit_id_i;
   logic                   commit_kill_i;
   logic                   result_valid_o;
   logic                   result_ready_i;
   logic [X_ID_WIDTH-1:0]  result_id_o;
   logic [X_RFR_WIDTH-1:0] result_data_o;
   logic [4:0]             result_rd_o;
   logic                   result_we_o;
   logic                   busy_o;

   modport slave (
      input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
      input  commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
      output issue_ready_o, issue_accept_o, issue_writeback_o,
      output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, busy_o
   );

   modport master (
      output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
      output commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
      input  issue_ready_o, issue_accept_o, issue_writeback_o,
      input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/xif_coproc_fifo.sv
`default_nettype none
// ====================================================================
// xif_coproc_fifo : circular in-flight buffer with id-match commit port
// Rev 1.0
// ====================================================================
module xif_coproc_fifo
   import xif_coproc_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    push_i,
   input  entry_t                  push_entry_i,
   input  logic                    pop_i,
   input  logic                    cmt_valid_i,
   input  logic [XIF_ID_MAX-1:0]   cmt_id_i,
   input  logic                    cmt_kill_i,
   output entry_t                  head_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    full_o
);
   localparam int unsigned        PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]     FULL_CNT = (PTR_W+1)'(DEPTH);

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + {{PTR_W{1'b0}}, push_i} - {{PTR_W{1'b0}}, pop_i};
      if (pop_i) begin
         mem_d[head_q] = '0;
         head_d        = head_q + PTR_W'(1);
      end
      if (push_i) begin
         mem_d[tail_q] = push_entry_i;
         tail_d        = tail_q + PTR_W'(1);
      end
      // Matching after the push lets a same-cycle commit hit the new entry.
      if (cmt_valid_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (mem_d[i].valid && !mem_d[i].committed && !mem_d[i].killed &&
                mem_d[i].id == cmt_id_i) begin
               if (cmt_kill_i) mem_d[i].killed    = 1'b1;
               else            mem_d[i].committed = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;
   assign full_o  = (count_q == FULL_CNT);

endmodule
`default_nettype wire

// File: rtl/xif_coproc_model.sv
`default_nettype none
// ====================================================================
// xif_coproc_model : CORE-V-XIF custom-0 coprocessor reference model
// Rev 1.0
// ====================================================================
module xif_coproc_model
   import xif_coproc_pkg::*;
#(
   parameter int unsigned X_ID_WIDTH  = 4,
   parameter int unsigned X_RFR_WIDTH = 32,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   xif_coproc_if.slave xif
);
   localparam logic [3:0] LAT_C = 4'(LATENCY);

   dec_t                     dec;
   entry_t                   push_entry, head;
   logic [XIF_ID_MAX-1:0]    cmt_id;
   logic [X_RFR_WIDTH-1:0]   alu_res;
   logic [$clog2(DEPTH):0]   count;
   logic                     full, push, pop, head_cmt, res_valid, res_hs;
   logic [3:0]               lat_cnt_q, lat_cnt_d;
   logic                     unused_bits;

   assign dec  = decode(xif.issue_instr_i[6:0], xif.issue_instr_i[14:12]);
   assign push = xif.issue_valid_i & ~full & dec.accept;

   always_comb begin
      alu_res = '0;
      case (dec.op)
         OP_ADD:  alu_res = xif.issue_rs1_i + xif.issue_rs2_i;
         OP_XOR:  alu_res = xif.issue_rs1_i ^ xif.issue_rs2_i;
         OP_SLL:  alu_res = xif.issue_rs1_i << xif.issue_rs2_i[4:0];
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      push_entry                        = '0;
      push_entry.valid                  = 1'b1;
      push_entry.id[X_ID_WIDTH-1:0]     = xif.issue_id_i;
      push_entry.rd                     = xif.issue_instr_i[11:7];
      push_entry.data[X_RFR_WIDTH-1:0]  = alu_res;
      cmt_id                            = '0;
      cmt_id[X_ID_WIDTH-1:0]            = xif.commit_id_i;
   end

   xif_coproc_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .cmt_valid_i  (xif.commit_valid_i),
      .cmt_id_i     (cmt_id),
      .cmt_kill_i   (xif.commit_kill_i),
      .head_o       (head),
      .count_o      (count),
      .full_o       (full)
   );

   // The latency counter only runs while a committed entry sits at the head.
   assign head_cmt  = head.valid & head.committed;
   assign res_valid = head_cmt & (lat_cnt_q == LAT_C);
   assign res_hs    = res_valid & xif.result_ready_i;
   assign pop       = (head.valid & head.killed) | res_hs;

   always_comb begin
      lat_cnt_d = lat_cnt_q;
      if (res_hs || !head_cmt)  lat_cnt_d = '0;
      else if (lat_cnt_q != LAT_C) lat_cnt_d = lat_cnt_q + 4'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) lat_cnt_q <= '0;
      else         lat_cnt_q <= lat_cnt_d;
   end

   assign xif.issue_ready_o     = ~full;
   assign xif.issue_accept_o    = dec.accept;
   assign xif.issue_writeback_o = dec.accept;
   assign xif.result_valid_o    = res_valid;
   assign xif.result_id_o       = head.id[X_ID_WIDTH-1:0];
   assign xif.result_data_o     = head.data[X_RFR_WIDTH-1:0];
   assign xif.result_rd_o       = head.rd;
   assign xif.result_we_o       = res_valid;
   assign xif.busy_o            = (count != '0);

   assign unused_bits = ^{head.id, head.data, xif.issue_instr_i[31:15]};

endmodule
`default_nettype wire

// File: tb/tb_xif_coproc_model.sv
`default_nettype none
// ====================================================================
// tb_xif_coproc_model : directed and randomized bench with queue model
// Rev 1.0
// ====================================================================
module tb_xif_coproc_model;
   localparam int IDW   = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int LAT   = 2;
   localparam logic [6:0] OPC = 7'b0001011;

   logic clk    = 1'b0;
   logic rst_ni = 1'b1;
   always #5 clk = ~clk;

   xif_coproc_if #(.X_ID_WIDTH(IDW), .X_RFR_WIDTH(DW)) xif ();

   xif_coproc_model #(
      .X_ID_WIDTH(IDW), .X_RFR_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .xif    (xif)
   );

   typedef struct {
      logic [3:0]  id;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t iss_q[$];
   bit   killed[16];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_accept(input logic [31:0] instr);
      return (instr[6:0] == OPC) && (instr[14:12] <= 3'd2);
   endfunction

   function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return a + b;
         3'd1:    return a ^ b;
         3'd2:    return a << b[4:0];
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
      logic [31:0] r;
      r = $urandom;
      return {r[31:15], f3, rd, opc};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      xif.issue_valid_i  = 1'b0;
      xif.issue_instr_i  = '0;
      xif.issue_id_i     = '0;
      xif.issue_rs1_i    = '0;
      xif.issue_rs2_i    = '0;
      xif.commit_valid_i = 1'b0;
      xif.commit_id_i    = '0;
      xif.commit_kill_i  = 1'b0;
      xif.result_ready_i = 1'b0;
   endtask

   task automatic do_issue(input logic [3:0] id, input logic [31:0] instr, input logic [31:0] a,
                           input logic [31:0] b, input bit cmt, input bit kill);
      int   guard;
      exp_t e;
      guard = 0;
      xif.issue_valid_i  = 1'b1;
      xif.issue_instr_i  = instr;
      xif.issue_id_i     = id;
      xif.issue_rs1_i    = a;
      xif.issue_rs2_i    = b;
      xif.commit_valid_i = cmt;
      xif.commit_id_i    = id;
      xif.commit_kill_i  = kill;
      #1;
      while (!xif.issue_ready_o && guard < 64) begin
         tick();
         guard++;
      end
      chk("issue_ready", xif.issue_ready_o, 1'b1);
      chk("issue_accept", xif.issue_accept_o, model_accept(instr));
      chk("issue_writeback", xif.issue_writeback_o, model_accept(instr));
      if (model_accept(instr)) begin
         e.id   = id;
         e.rd   = instr[11:7];
         e.data = ref_alu(instr[14:12], a, b);
         iss_q.push_back(e);
         killed[id] = cmt && kill;
      end
      tick();
      xif.issue_valid_i  = 1'b0;
      xif.commit_valid_i = 1'b0;
      xif.commit_kill_i  = 1'b0;
   endtask

   task automatic do_commit(input logic [3:0] id, input bit kill);
      xif.commit_valid_i = 1'b1;
      xif.commit_id_i    = id;
      xif.commit_kill_i  = kill;
      if (kill) killed[id] = 1'b1;
      tick();
      xif.commit_valid_i = 1'b0;
      xif.commit_kill_i  = 1'b0;
   endtask

   task automatic collect(input int n, input bit rnd);
      int   got;
      int   guard;
      exp_t e;
      logic r;
      got   = 0;
      guard = 0;
      while (got < n && guard < 400) begin
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         xif.result_ready_i = r;
         @(negedge clk);
         if (xif.result_valid_o && r) begin
            while (iss_q.size() > 0 && killed[iss_q[0].id]) void'(iss_q.pop_front());
            if (iss_q.size() == 0) begin
               chk("res_unexpected", xif.result_valid_o, 1'b0);
            end else begin
               e = iss_q.pop_front();
               chk("res_id", xif.result_id_o, e.id);
               chk("res_data", xif.result_data_o, e.data);
               chk("res_rd", xif.result_rd_o, e.rd);
               chk("res_we", xif.result_we_o, 1'b1);
            end
            got++;
         end
         tick();
         guard++;
      end
      xif.result_ready_i = 1'b0;
      chk("res_count", got, n);
   endtask

   task automatic drain(input int cycles);
      bit seen;
      seen = 1'b0;
      xif.result_ready_i = 1'b1;
      repeat (cycles) begin
         @(negedge clk);
         if (xif.result_valid_o) seen = 1'b1;
         tick();
      end
      xif.result_ready_i = 1'b0;
      chk("no_extra_result", seen, 1'b0);
      chk("busy_idle", xif.busy_o, 1'b0);
      iss_q.delete();
   endtask

   initial begin : stim
      logic [31:0] instr;
      logic [31:0] a, b;
      logic [3:0]  ids[$];
      logic [3:0]  tmp;
      logic [3:0]  id;
      int          nid;
      int          n, n_surv, j, guard;
      bit          same, kill;
      logic [2:0]  f3;
      logic [6:0]  opc;

      idle_inputs();
      #2 rst_ni = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_issue_ready", xif.issue_ready_o, 1'b1);
      chk("rst_result_valid", xif.result_valid_o, 1'b0);
      chk("rst_busy", xif.busy_o, 1'b0);
      chk("rst_accept", xif.issue_accept_o, 1'b0);
      chk("rst_result_we", xif.result_we_o, 1'b0);
      chk("rst_result_data", xif.result_data_o, 32'h0);
      rst_ni = 1'b1;
      tick();

      // ADD with commit one cycle after issue: exact latency check
      instr = mk_instr(OPC, 3'b000, 5'd9);
      do_issue(4'd3, instr, 32'd5, 32'd7, 1'b0, 1'b0);
      chk("t1_busy", xif.busy_o, 1'b1);
      chk("t1_no_early_result", xif.result_valid_o, 1'b0);
      xif.commit_valid_i = 1'b1;
      xif.commit_id_i    = 4'd3;
      xif.commit_kill_i  = 1'b0;
      tick();
      xif.commit_valid_i = 1'b0;
      chk("t1_lat_cycle0", xif.result_valid_o, 1'b0);
      tick();
      chk("t1_lat_cycle1", xif.result_valid_o, 1'b0);
      tick();
      chk("t1_lat_cycle2", xif.result_valid_o, 1'b1);
      chk("t1_data", xif.result_data_o, 32'd12);
      chk("t1_id", xif.result_id_o, 4'd3);
      chk("t1_rd", xif.result_rd_o, 5'd9);
      collect(1, 1'b0);
      drain(6);

      // Illegal opcode is rejected and never produces a result
      instr = mk_instr(7'b0110011, 3'b000, 5'd1);
      do_issue(4'd1, instr, 32'd1, 32'd2, 1'b0, 1'b0);
      chk("t2_busy", xif.busy_o, 1'b0);
      drain(8);

      // Fill to DEPTH, then commit all and return in order
      for (int i = 0; i < DEPTH; i++)
         do_issue(4'(i), mk_instr(OPC, 3'b000, 5'(i + 1)), 32'(i), 32'd100, 1'b0, 1'b0);
      chk("t3_ready_full", xif.issue_ready_o, 1'b0);
      chk("t3_busy_full", xif.busy_o, 1'b1);
      for (int i = 0; i < DEPTH; i++) do_commit(4'(i), 1'b0);
      chk("t3_ready_still_full", xif.issue_ready_o, 1'b0);
      collect(1, 1'b0);
      chk("t3_ready_after_first", xif.issue_ready_o, 1'b1);
      collect(DEPTH - 1, 1'b1);
      drain(6);

      // Kill one, commit the other
      do_issue(4'd5, mk_instr(OPC, 3'b000, 5'd5), 32'd50, 32'd1, 1'b0, 1'b0);
      do_issue(4'd6, mk_instr(OPC, 3'b001, 5'd6), 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0, 1'b0);
      do_commit(4'd5, 1'b1);
      do_commit(4'd6, 1'b0);
      collect(1, 1'b0);
      drain(8);

      // Commit in the same cycle as issue
      do_issue(4'd7, mk_instr(OPC, 3'b001, 5'd12), 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 1'b0);
      guard = 0;
      while (!xif.result_valid_o && guard < 20) begin
         tick();
         guard++;
      end
      chk("t5_valid", xif.result_valid_o, 1'b1);
      chk("t5_data", xif.result_data_o, 32'hF0F0_0F0F);
      collect(1, 1'b0);
      drain(6);

      // Held result stays stable, then reset mid-stall clears it at once
      do_issue(4'd2, mk_instr(OPC, 3'b000, 5'd3), 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
      do_commit(4'd2, 1'b0);
      guard = 0;
      while (!xif.result_valid_o && guard < 20) begin
         tick();
         guard++;
      end
      chk("t6_valid", xif.result_valid_o, 1'b1);
      repeat (5) begin
         tick();
         chk("t6_hold_valid", xif.result_valid_o, 1'b1);
         chk("t6_hold_id", xif.result_id_o, 4'd2);
         chk("t6_hold_data", xif.result_data_o, 32'd1);
      end
      #2 rst_ni = 1'b0;
      #1;
      chk("t6_rst_valid", xif.result_valid_o, 1'b0);
      chk("t6_rst_busy", xif.busy_o, 1'b0);
      iss_q.delete();
      tick();
      rst_ni = 1'b1;
      drain(8);

      // Randomized batches: mixed ops, out-of-order commits, kills, random ready
      nid = 8;
      repeat (25) begin
         ids.delete();
         n = $urandom_range(1, DEPTH);
         for (int k = 0; k < n; k++) begin
            id   = 4'(nid);
            nid++;
            opc  = ($urandom_range(0, 7) == 0) ? 7'b0110011 : OPC;
            f3   = 3'($urandom_range(0, 3));
            a    = $urandom;
            b    = $urandom;
            same = ($urandom_range(0, 3) == 0);
            kill = ($urandom_range(0, 2) == 0);
            instr = mk_instr(opc, f3, 5'($urandom_range(0, 31)));
            do_issue(id, instr, a, b, same, kill);
            if (model_accept(instr) && !same) ids.push_back(id);
         end
         for (int k = ids.size() - 1; k > 0; k--) begin
            j = $urandom_range(0, k);
            tmp    = ids[k];
            ids[k] = ids[j];
            ids[j] = tmp;
         end
         foreach (ids[k]) do_commit(ids[k], ($urandom_range(0, 2) == 0));
         n_surv = 0;
         foreach (iss_q[k]) if (!killed[iss_q[k].id]) n_surv++;
         collect(n_surv, 1'b1);
         drain(2 * DEPTH + LAT + 4);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
